// File: rtl/program_loader_pkg.sv
// Shared constants for the program memory loader: FSM state encodings and frame geometry.
// The optional trailing checksum byte is enabled by defining CHECKSUM_EN.
package program_loader_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

    localparam int LEN_BYTES          = 2;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;

    function automatic int bytes_per_word(input int dataWidth);
        return dataWidth / 8;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects stream bytes into one little-endian word; the first byte of a word lands in [7:0].
module word_assembler
    import program_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clear,
    input  logic                  i_accept,
    input  logic [7:0]            i_byte,
    output logic                  o_wordFull,
    output logic [DATA_WIDTH-1:0] o_word
);

    localparam int BPW    = bytes_per_word(DATA_WIDTH);
    localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BPW - 1);

    logic [LANE_W-1:0]     r_lane;
    logic [DATA_WIDTH-1:0] r_shift;

    // Bytes enter at the top and shift down, so after a full word the oldest byte sits in [7:0].
    // o_word already includes the byte being accepted, letting the caller latch a complete word
    // on the same edge as the final handshake.
    assign o_word     = {i_byte, r_shift[DATA_WIDTH-1:8]};
    assign o_wordFull = i_accept && (r_lane == LAST_LANE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lane  <= '0;
            r_shift <= '0;
        end else if (i_clear) begin
            r_lane  <= '0;
            r_shift <= '0;
        end else if (i_accept) begin
            r_shift <= o_word;
            r_lane  <= o_wordFull ? '0 : r_lane + LANE_W'(1);
        end
    end

endmodule

// File: rtl/program_memory_loader.sv
// Loads a length-prefixed byte stream word-by-word into program memory while holding the CPU stalled.
// Define CHECKSUM_EN to require a trailing XOR checksum byte over all data bytes.
module program_memory_loader
    import program_loader_pkg::*;
#(
    parameter int MEMORY_DEPTH = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [7:0]            ByteIn,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic                  MemWrite,
    output logic [DATA_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0] MemWriteData,
    output logic                  CpuHold,
    output logic                  Done,
    output logic                  Error
);

    localparam logic [15:0] MAX_WORDS = 16'(MEMORY_DEPTH);

    logic [2:0]            r_state;
    logic [15:0]           r_count;
    logic [15:0]           r_index;
    logic                  r_memWrite;
    logic [DATA_WIDTH-1:0] r_memAddress;
    logic [DATA_WIDTH-1:0] r_memWriteData;
`ifdef CHECKSUM_EN
    logic [7:0]            r_checksum;
`endif

    logic                  w_accept;
    logic                  w_dataAccept;
    logic                  w_startOk;
    logic                  w_wordFull;
    logic                  w_lenBad;
    logic [15:0]           w_lenNext;
    logic [DATA_WIDTH-1:0] w_word;

    assign ByteReady    = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                          (r_state == S_DATA)   || (r_state == S_CHECK);
    assign w_accept     = ByteValid && ByteReady;
    assign w_dataAccept = w_accept && (r_state == S_DATA);
    assign w_startOk    = Start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
    assign w_lenNext    = {ByteIn, r_count[7:0]};
    assign w_lenBad     = (w_lenNext == 16'd0) || (w_lenNext > MAX_WORDS);

    word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_assembler (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_startOk),
        .i_accept   (w_dataAccept),
        .i_byte     (ByteIn),
        .o_wordFull (w_wordFull),
        .o_word     (w_word)
    );

    // Address and data are latched on the final byte handshake so they are valid throughout WRITE
    // and keep the last written word afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_count        <= '0;
            r_index        <= '0;
            r_memWrite     <= 1'b0;
            r_memAddress   <= '0;
            r_memWriteData <= '0;
`ifdef CHECKSUM_EN
            r_checksum     <= '0;
`endif
        end else begin
            r_memWrite <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (Start) begin
                        r_state    <= S_LEN_LO;
                        r_count    <= '0;
                        r_index    <= '0;
`ifdef CHECKSUM_EN
                        r_checksum <= '0;
`endif
                    end
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_count[7:0] <= ByteIn;
                        r_state      <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) begin
                        r_count <= w_lenNext;
                        r_index <= '0;
                        r_state <= w_lenBad ? S_ERROR : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
`ifdef CHECKSUM_EN
                        r_checksum <= r_checksum ^ ByteIn;
`endif
                        if (w_wordFull) begin
                            r_memWrite     <= 1'b1;
                            r_memAddress   <= DATA_WIDTH'(r_index) << 2;
                            r_memWriteData <= w_word;
                            r_state        <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_index <= r_index + 16'd1;
                    if (r_index == r_count - 16'd1) begin
`ifdef CHECKSUM_EN
                        r_state <= S_CHECK;
`else
                        r_state <= S_DONE;
`endif
                    end else begin
                        r_state <= S_DATA;
                    end
                end
`ifdef CHECKSUM_EN
                S_CHECK: begin
                    if (w_accept) begin
                        r_state <= (ByteIn == r_checksum) ? S_DONE : S_ERROR;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // An aborted load keeps the CPU stalled so a partial program never runs.
    assign MemWrite     = r_memWrite;
    assign MemAddress   = r_memAddress;
    assign MemWriteData = r_memWriteData;
    assign Done         = (r_state == S_DONE);
    assign Error        = (r_state == S_ERROR);
    assign CpuHold      = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule

// File: tb/tb_program_memory_loader.sv
// Scoreboard bench for program_memory_loader; expected memory writes are queued as bytes are sent.
// Exercises the checksum frame too when compiled with CHECKSUM_EN.
module tb_program_memory_loader;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        start     = 1'b0;
    logic [7:0]  byteIn    = 8'h00;
    logic        byteValid = 1'b0;
    logic        byteReady;
    logic        memWrite;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        cpuHold;
    logic        done;
    logic        error;

    int          checkCount  = 0;
    int          passCount   = 0;
    bit          randomValid = 1'b0;
    logic [63:0] expQ[$];
    logic [31:0] wordBuf[64];
`ifdef CHECKSUM_EN
    bit          corruptSum  = 1'b0;
`endif

    program_memory_loader #(
        .MEMORY_DEPTH (32),
        .DATA_WIDTH   (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Start        (start),
        .ByteIn       (byteIn),
        .ByteValid    (byteValid),
        .ByteReady    (byteReady),
        .MemWrite     (memWrite),
        .MemAddress   (memAddress),
        .MemWriteData (memWriteData),
        .CpuHold      (cpuHold),
        .Done         (done),
        .Error        (error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        else
            passCount++;
    endtask

    // Scoreboard consumer: every write strobe must match the oldest queued word.
    initial begin : writeMonitor
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (memWrite === 1'b1) begin
                checkOutput("ready_low_in_write", {63'd0, byteReady}, 64'd0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_write", 64'd1, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("write_addr", {32'd0, memAddress}, {32'd0, e[63:32]});
                    checkOutput("write_data", {32'd0, memWriteData}, {32'd0, e[31:0]});
                end
            end
        end
    end

    task automatic applyByte(input logic [7:0] b);
        int waited;
        if (randomValid) repeat ($urandom_range(0, 3)) @(negedge clk);
        byteIn    = b;
        byteValid = 1'b1;
        waited    = 0;
        while (byteReady !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) checkOutput("byte_accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
        byteValid = 1'b0;
    endtask

    task automatic applyStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_hold", {63'd0, cpuHold}, 64'd1);
        checkOutput("start_clears_done", {63'd0, done}, 64'd0);
        checkOutput("start_clears_error", {63'd0, error}, 64'd0);
    endtask

    task automatic applyStimulus(input int n, input int startPulseAfter);
        logic [7:0]  sum;
        logic [7:0]  bt;
        logic [31:0] w32;
        logic [15:0] len;
        int          idx;
        len = 16'(n);
        applyStart();
        applyByte(len[7:0]);
        applyByte(len[15:8]);
        sum = 8'h00;
        idx = 0;
        for (int w = 0; w < n; w++) begin
            w32 = wordBuf[w];
            expQ.push_back({32'(w) << 2, w32});
            for (int k = 0; k < 4; k++) begin
                bt = w32[8*k +: 8];
                applyByte(bt);
                sum = sum ^ bt;
                if (idx == startPulseAfter) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                    checkOutput("start_ignored_hold", {63'd0, cpuHold}, 64'd1);
                end
                idx++;
            end
        end
`ifdef CHECKSUM_EN
        applyByte(corruptSum ? (sum ^ 8'h07) : sum);
`endif
    endtask

    task automatic waitFinal(input bit expectDone, input string tag);
        int k;
        k = 0;
        while (done !== 1'b1 && error !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
        checkOutput({tag, "_done"}, {63'd0, done}, {63'd0, expectDone});
        checkOutput({tag, "_error"}, {63'd0, error}, {63'd0, !expectDone});
        checkOutput({tag, "_hold"}, {63'd0, cpuHold}, {63'd0, !expectDone});
        checkOutput({tag, "_pending"}, 64'(expQ.size()), 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        checkOutput("global_timeout", 64'd0, 64'd1);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin : mainSeq
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", {63'd0, byteReady}, 64'd0);
        checkOutput("rst_write", {63'd0, memWrite}, 64'd0);
        checkOutput("rst_addr", {32'd0, memAddress}, 64'd0);
        checkOutput("rst_data", {32'd0, memWriteData}, 64'd0);
        checkOutput("rst_hold", {63'd0, cpuHold}, 64'd0);
        checkOutput("rst_done", {63'd0, done}, 64'd0);
        checkOutput("rst_error", {63'd0, error}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Two-word reference program with ByteValid held across each WRITE
        wordBuf[0] = 32'h20080013;
        wordBuf[1] = 32'h20090014;
        applyStimulus(2, -1);
        waitFinal(1'b1, "two_words");
        checkOutput("hold_addr", {32'd0, memAddress}, 64'h4);
        checkOutput("hold_data", {32'd0, memWriteData}, 64'h20090014);
        checkOutput("hold_write", {63'd0, memWrite}, 64'd0);

        // Zero length and one-past-depth length both abort without writing
        applyStart();
        applyByte(8'h00);
        applyByte(8'h00);
        waitFinal(1'b0, "len_zero");
        applyStart();
        applyByte(8'h21);
        applyByte(8'h00);
        waitFinal(1'b0, "len_33");

        // Random ByteValid gaps
        randomValid = 1'b1;
        for (int i = 0; i < 8; i++) wordBuf[i] = $urandom;
        applyStimulus(8, -1);
        waitFinal(1'b1, "random_gaps");

        // Largest legal program fills the whole memory
        for (int i = 0; i < 32; i++) wordBuf[i] = $urandom;
        applyStimulus(32, -1);
        waitFinal(1'b1, "full_depth");
        checkOutput("full_last_addr", {32'd0, memAddress}, 64'h7C);

        // Start pulsed mid-word is ignored
        randomValid = 1'b0;
        for (int i = 0; i < 3; i++) wordBuf[i] = $urandom;
        applyStimulus(3, 5);
        waitFinal(1'b1, "start_in_data");

`ifdef CHECKSUM_EN
        wordBuf[0] = 32'h20080013;
        corruptSum = 1'b0;
        applyStimulus(1, -1);
        waitFinal(1'b1, "sum_good");
        corruptSum = 1'b1;
        applyStimulus(1, -1);
        waitFinal(1'b0, "sum_bad");
        corruptSum = 1'b0;
`endif

        // Reset in DATA after six bytes: first word already written, nothing more afterwards
        wordBuf[0] = 32'hA5A55A5A;
        applyStart();
        applyByte(8'h02);
        applyByte(8'h00);
        expQ.push_back({32'h0, wordBuf[0]});
        applyByte(8'h5A);
        applyByte(8'h5A);
        applyByte(8'hA5);
        applyByte(8'hA5);
        repeat (2) @(negedge clk);
        checkOutput("pre_reset_hold", {63'd0, cpuHold}, 64'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("midrst_ready", {63'd0, byteReady}, 64'd0);
        checkOutput("midrst_write", {63'd0, memWrite}, 64'd0);
        checkOutput("midrst_addr", {32'd0, memAddress}, 64'd0);
        checkOutput("midrst_data", {32'd0, memWriteData}, 64'd0);
        checkOutput("midrst_hold", {63'd0, cpuHold}, 64'd0);
        checkOutput("midrst_done", {63'd0, done}, 64'd0);
        checkOutput("midrst_error", {63'd0, error}, 64'd0);
        @(negedge clk);
        reset     = 1'b1;
        byteIn    = 8'h55;
        byteValid = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("idle_ready", {63'd0, byteReady}, 64'd0);
        checkOutput("idle_hold", {63'd0, cpuHold}, 64'd0);
        checkOutput("idle_pending", 64'(expQ.size()), 64'd0);
        byteValid = 1'b0;

        // Recovery load after the abort
        wordBuf[0] = 32'h0000006F;
        applyStimulus(1, -1);
        waitFinal(1'b1, "after_reset");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
